// File: rtl/score_counter.sv
// rtl/score_counter.sv - up/down score counter with synchronised button events, clear, load, wrap/saturate
module score_counter #(
    parameter int MAX_VAL     = 99,
    parameter int WIDTH       = 7,
    parameter int WRAP        = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             up_i,
    input  logic             down_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_val_o,
    output logic             at_max_o,
    output logic             at_min_o,
    output logic             ovf_o,
    output logic             unf_o
);

    generate
        if (MAX_VAL >= (1 << WIDTH)) begin : g_width_chk
            $fatal(1, "score_counter: WIDTH too small to hold MAX_VAL");
        end
        if (SYNC_STAGES < 2) begin : g_sync_chk
            $fatal(1, "score_counter: SYNC_STAGES must be at least 2");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [SYNC_STAGES-1:0] up_sync;
    logic [SYNC_STAGES-1:0] dn_sync;
    logic                   up_prev;
    logic                   dn_prev;
    logic                   up_evt;
    logic                   dn_evt;

    logic [WIDTH-1:0]       cnt_nxt;
    logic                   ovf_nxt;
    logic                   unf_nxt;

    assign up_evt   = up_sync[SYNC_STAGES-1] & ~up_prev;
    assign dn_evt   = dn_sync[SYNC_STAGES-1] & ~dn_prev;
    assign at_max_o = (cnt_val_o == MAX_W);
    assign at_min_o = (cnt_val_o == '0);

    // Clear and load swallow any coincident event, so flags can only come from the event branches.
    always_comb begin
        cnt_nxt = cnt_val_o;
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
        if (clr_i) begin
            cnt_nxt = '0;
        end else if (load_i) begin
            cnt_nxt = (load_val_i > MAX_W) ? MAX_W : load_val_i;
        end else if (up_evt && !dn_evt) begin
            if (cnt_val_o == MAX_W) begin
                ovf_nxt = 1'b1;
                cnt_nxt = (WRAP != 0) ? '0 : MAX_W;
            end else begin
                cnt_nxt = cnt_val_o + 1'b1;
            end
        end else if (dn_evt && !up_evt) begin
            if (cnt_val_o == '0) begin
                unf_nxt = 1'b1;
                cnt_nxt = (WRAP != 0) ? MAX_W : '0;
            end else begin
                cnt_nxt = cnt_val_o - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            up_sync   <= '0;
            dn_sync   <= '0;
            up_prev   <= 1'b0;
            dn_prev   <= 1'b0;
            cnt_val_o <= '0;
            ovf_o     <= 1'b0;
            unf_o     <= 1'b0;
        end else begin
            up_sync   <= {up_sync[SYNC_STAGES-2:0], up_i};
            dn_sync   <= {dn_sync[SYNC_STAGES-2:0], down_i};
            up_prev   <= up_sync[SYNC_STAGES-1];
            dn_prev   <= dn_sync[SYNC_STAGES-1];
            cnt_val_o <= cnt_nxt;
            ovf_o     <= ovf_nxt;
            unf_o     <= unf_nxt;
        end
    end

endmodule

// File: tb/tb_score_counter.sv
// tb/tb_score_counter.sv - randomized and directed bench for score_counter against a behavioural model
module tb_score_counter;

    localparam int S    = 2;
    localparam int MAXE = 16384;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       up [2];
    logic       dn [2];
    logic       clr [2];
    logic       ld [2];
    logic [6:0] ldv0 = '0;
    logic [3:0] ldv1 = '0;

    logic [6:0] cnt0;
    logic [3:0] cnt1;
    logic       amax0, amin0, ovf0, unf0;
    logic       amax1, amin1, ovf1, unf1;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    always #5 clk = ~clk;

    score_counter dut0 (
        .clk_i(clk), .rst_i(rst_n), .up_i(up[0]), .down_i(dn[0]), .clr_i(clr[0]),
        .load_i(ld[0]), .load_val_i(ldv0), .cnt_val_o(cnt0), .at_max_o(amax0),
        .at_min_o(amin0), .ovf_o(ovf0), .unf_o(unf0)
    );

    score_counter #(.MAX_VAL(9), .WIDTH(4), .WRAP(1), .SYNC_STAGES(S)) dut1 (
        .clk_i(clk), .rst_i(rst_n), .up_i(up[1]), .down_i(dn[1]), .clr_i(clr[1]),
        .load_i(ld[1]), .load_val_i(ldv1), .cnt_val_o(cnt1), .at_max_o(amax1),
        .at_min_o(amin1), .ovf_o(ovf1), .unf_o(unf1)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: an input rise sampled at edge k becomes a count event at edge k+S,
    // unless a reset edge lies in between.
    int mv [2] = '{99, 9};
    int wr [2] = '{0, 1};
    int m_cnt [2];
    int m_ovf [2];
    int m_unf [2];
    bit su [2][MAXE];
    bit sd [2][MAXE];
    int e = 0;
    int last_rst = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit ue, de;
            int v;
            if (!rst_n) begin
                m_cnt[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
                su[i][e] = 0; sd[i][e] = 0;
            end else begin
                su[i][e] = up[i];
                sd[i][e] = dn[i];
                ue = (e - S > last_rst) && su[i][e-S] && !su[i][e-S-1];
                de = (e - S > last_rst) && sd[i][e-S] && !sd[i][e-S-1];
                v  = (i == 0) ? int'(ldv0) : int'(ldv1);
                m_ovf[i] = 0;
                m_unf[i] = 0;
                if (clr[i]) m_cnt[i] = 0;
                else if (ld[i]) m_cnt[i] = (v > mv[i]) ? mv[i] : v;
                else if (ue && !de) begin
                    if (m_cnt[i] == mv[i]) begin
                        m_ovf[i] = 1;
                        m_cnt[i] = wr[i] ? 0 : mv[i];
                    end else m_cnt[i] = m_cnt[i] + 1;
                end else if (de && !ue) begin
                    if (m_cnt[i] == 0) begin
                        m_unf[i] = 1;
                        m_cnt[i] = wr[i] ? mv[i] : 0;
                    end else m_cnt[i] = m_cnt[i] - 1;
                end
            end
        end
        if (!rst_n) last_rst = e;
        e++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check_eq("cnt0", int'(cnt0), m_cnt[0]);
            check_eq("at_max0", int'(amax0), int'(m_cnt[0] == 99));
            check_eq("at_min0", int'(amin0), int'(m_cnt[0] == 0));
            check_eq("ovf0", int'(ovf0), m_ovf[0]);
            check_eq("unf0", int'(unf0), m_unf[0]);
            check_eq("cnt1", int'(cnt1), m_cnt[1]);
            check_eq("at_max1", int'(amax1), int'(m_cnt[1] == 9));
            check_eq("at_min1", int'(amin1), int'(m_cnt[1] == 0));
            check_eq("ovf1", int'(ovf1), m_ovf[1]);
            check_eq("unf1", int'(unf1), m_unf[1]);
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic run_count(input int i, input int n, output int no, output int nu);
        no = 0;
        nu = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            no += (i == 0) ? int'(ovf0) : int'(ovf1);
            nu += (i == 0) ? int'(unf0) : int'(unf1);
        end
    endtask

    task automatic load0(input int v);
        ld[0] = 1'b1; ldv0 = 7'(v);
        tick(1);
        ld[0] = 1'b0;
    endtask

    initial begin
        int no, nu;
        for (int i = 0; i < 2; i++) begin
            up[i] = 0; dn[i] = 0; clr[i] = 0; ld[i] = 0;
        end

        // reset release
        tick(2);
        chk_en = 1;
        rst_n = 1'b1;
        check_eq("rst_cnt", int'(cnt0), 0);
        check_eq("rst_at_min", int'(amin0), 1);
        check_eq("rst_at_max", int'(amax0), 0);
        check_eq("rst_ovf", int'(ovf0), 0);
        check_eq("rst_unf", int'(unf0), 0);
        tick(2);

        // latency: update on edge 3, held level counts once
        up[0] = 1'b1;
        tick(1); check_eq("lat_e1", int'(cnt0), 0);
        tick(1); check_eq("lat_e2", int'(cnt0), 0);
        tick(1); check_eq("lat_e3", int'(cnt0), 1);
        tick(7); check_eq("hold_once", int'(cnt0), 1);
        for (int k = 0; k < 98; k++) begin
            up[0] = 1'b0; tick(1);
            up[0] = 1'b1; tick(1);
        end
        tick(3);
        check_eq("count_99", int'(cnt0), 99);
        check_eq("at_max_99", int'(amax0), 1);

        // saturate at limits
        up[0] = 1'b0; tick(1); up[0] = 1'b1;
        run_count(0, 6, no, nu);
        check_eq("sat_ovf_pulses", no, 1);
        check_eq("sat_cnt", int'(cnt0), 99);
        load0(0);
        check_eq("load0_cnt", int'(cnt0), 0);
        dn[0] = 1'b1;
        run_count(0, 6, no, nu);
        check_eq("sat_unf_pulses", nu, 1);
        check_eq("sat_cnt0", int'(cnt0), 0);

        // wrap instance
        ld[1] = 1'b1; ldv1 = 4'd9; tick(1); ld[1] = 1'b0;
        check_eq("w_load9", int'(cnt1), 9);
        up[1] = 1'b1;
        run_count(1, 6, no, nu);
        check_eq("w_ovf_pulses", no, 1);
        check_eq("w_wrap_up", int'(cnt1), 0);
        dn[1] = 1'b1;
        run_count(1, 6, no, nu);
        check_eq("w_unf_pulses", nu, 1);
        check_eq("w_wrap_dn", int'(cnt1), 9);
        up[1] = 1'b0; dn[1] = 1'b0;

        // priority and coincidence
        up[0] = 1'b0; dn[0] = 1'b0; tick(3);
        load0(120);
        check_eq("load_clamp", int'(cnt0), 99);
        load0(50);
        up[0] = 1'b1; dn[0] = 1'b1;
        run_count(0, 6, no, nu);
        check_eq("cancel_cnt", int'(cnt0), 50);
        check_eq("cancel_flags", no + nu, 0);
        up[0] = 1'b0; dn[0] = 1'b0; tick(3);
        load0(99);
        up[0] = 1'b1; tick(2);
        clr[0] = 1'b1; tick(1); clr[0] = 1'b0;
        check_eq("clr_wins", int'(cnt0), 0);
        run_count(0, 4, no, nu);
        check_eq("clr_no_ovf", no, 0);
        check_eq("clr_dropped", int'(cnt0), 0);

        // reset mid-operation with up held
        up[0] = 1'b0; tick(3);
        load0(41);
        up[0] = 1'b1; tick(4);
        check_eq("pre_rst_42", int'(cnt0), 42);
        rst_n = 1'b0; tick(1); rst_n = 1'b1;
        check_eq("mid_rst_cnt", int'(cnt0), 0);
        tick(1); check_eq("rel_e1", int'(cnt0), 0);
        tick(1); check_eq("rel_e2", int'(cnt0), 0);
        tick(1); check_eq("rel_e3", int'(cnt0), 1);
        tick(5); check_eq("rel_once", int'(cnt0), 1);

        // random traffic on both instances
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(0, 2) == 0) up[i] = ~up[i];
                if ($urandom_range(0, 3) == 0) dn[i] = ~dn[i];
                clr[i] = ($urandom_range(0, 60) == 0);
                ld[i]  = ($urandom_range(0, 40) == 0);
            end
            ldv0  = 7'($urandom_range(0, 127));
            ldv1  = 4'($urandom_range(0, 15));
            rst_n = ($urandom_range(0, 299) != 0);
            tick(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
